// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB write-back stage with 32x32 register file, bypass and retire counter
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 32,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_alu_res,
  input  logic [DATA_W-1:0] wb_dm_q,
  input  logic [DATA_W-1:0] wb_next_pc,
  input  logic [1:0]        wb_rf_d_sel,
  input  logic [1:0]        wb_rd_sel,
  input  logic [AW-1:0]     wb_rt,
  input  logic [AW-1:0]     wb_rd,
  input  logic [AW-1:0]     id_ra1,
  input  logic [AW-1:0]     id_ra2,
  output logic [DATA_W-1:0] id_rd1,
  output logic [DATA_W-1:0] id_rd2,
  output logic              fwd_we,
  output logic [AW-1:0]     fwd_waddr,
  output logic [DATA_W-1:0] fwd_wdata,
  output logic [CNT_W-1:0]  retired
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [DATA_W-1:0] wdata;
  logic [AW-1:0]     waddr;
  logic              we;

  always_comb begin
    wdata = '0;
    case (wb_rf_d_sel)
      2'd0:    wdata = wb_alu_res;
      2'd1:    wdata = wb_dm_q;
      2'd2:    wdata = wb_next_pc;
      default: wdata = '0;
    endcase
  end

  always_comb begin
    waddr = '0;
    case (wb_rd_sel)
      2'd0:    waddr = wb_rt;
      2'd1:    waddr = wb_rd;
      2'd2:    waddr = AW'(LINK_REG);
      default: waddr = '0;
    endcase
  end

  // Excluding r0 here keeps it zero in storage and keeps it out of the bypass and forwarding paths.
  assign we = wb_valid && (wb_rf_d_sel != 2'd3) && (wb_rd_sel != 2'd3) && (waddr != '0);

  assign fwd_we    = we;
  assign fwd_waddr = we ? waddr : '0;
  assign fwd_wdata = we ? wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    if (id_ra1 == '0)                 id_rd1 = '0;
    else if (we && id_ra1 == waddr)   id_rd1 = wdata;
    else                              id_rd1 = regs_q[id_ra1];
  end

  always_comb begin
    if (id_ra2 == '0)                 id_rd2 = '0;
    else if (we && id_ra2 == waddr)   id_rd2 = wdata;
    else                              id_rd2 = regs_q[id_ra2];
  end

  // Counts every valid slot, including stores and branches that never write.
  assign retired_d = wb_valid ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= '0;
    else        retired_q <= retired_d;
  end

  assign retired = retired_q;

endmodule
